serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-multiplexes a single 1-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first. The block accepts operands on a start/busy/done handshake, sequences the cell with a shift-register datapath and a carry flop, and presents the full-width sum plus carry-out. It is the sequencing layer above the lab's full-adder cell and trades latency for area.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH)+1, bit counter width; derived, not overridden.

Ports:
clk     input   1      single clock, rising edge
rst_n   input   1      asynchronous active-low reset
start   input   1      request; accepted only when state is IDLE
a       input   WIDTH  operand A, sampled on the accepted start
b       input   WIDTH  operand B, sampled on the accepted start
cin     input   1      carry-in, sampled on the accepted start
busy    output  1      high while bits are being processed (SHIFT)
done    output  1      one-cycle pulse when the result is valid
sum     output  WIDTH  result register
cout    output  1      final carry-out register

Behaviour:
- Reset (asynchronous on rst_n low, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry flop=0, operand shift registers=0. Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE: on start=1, latch a and b into shift registers, latch cin into the carry flop, clear the counter, go to SHIFT. With start=0, remain in IDLE. sum and cout hold their previous values.
- SHIFT, one bit per cycle:
  - The cell computes s = a_sh[0]^b_sh[0]^c and co = majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right; sum shifts right with s entering at MSB; c <= co; counter increments.
  - When the counter reaches WIDTH-1 in this cycle, go to DONE; cout <= co on the same edge.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Timing: start accepted at edge 0 -> busy high for cycles 1..WIDTH -> done high in cycle WIDTH+1. Total latency is WIDTH+1 cycles. Next start can be accepted in the cycle after done, giving a throughput of 1 operation per WIDTH+2 cycles.
- start while in SHIFT or DONE: ignored, with no effect on the operands or the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Intermediate sum bits are visible on sum during SHIFT and are only valid when done=1.
- sum and cout hold their values after DONE until the next accepted start.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: adds input port sub (1 bit, sampled with start). When sub=1, b is latched inverted and the carry flop is loaded with 1, ignoring cin. The result is a - b in two's complement; cout=1 means no borrow. Adds output ovf (1 bit, reset 0), registered at the DONE transition as carry-into-MSB XOR carry-out-of-MSB.
- Undefined: no sub or ovf ports; add only.

Decomposition:
- Shared package/include serial_add_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH localparam
- One sub-module: fa_cell (x, y, ci -> z, co). Purely combinational, carry = majority, instantiated once inside serial_add_ctrl.

Test Plan:
- a=8'h00, b=8'h00, cin=0, start pulse -> busy=1 for 8 cycles, done pulse at cycle 9, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
- start held high continuously with changing a/b during SHIFT -> only the first operands are used. Back-to-back ops accepted exactly every 10 cycles; done is never high two cycles in a row.
- rst_n low at cycle 4 of SHIFT, released next cycle -> sum=0, cout=0, busy=0, no done pulse. A new start then completes correctly.
- Exhaustive WIDTH=4 instance: all 512 (a,b,cin) combinations -> {cout,sum} matches the reference sum at every done.
- With SERIAL_ADD_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t      : controller state encoding (2 bits)
//   - DEFAULT_WIDTH: default operand width for serial_add_ctrl
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Single-bit full adder. Purely combinational.
// Ports:
//   x, y  : operand bits
//   ci    : carry in
//   z     : sum bit
//   co    : carry out (majority of x, y, ci)
// ---------------------------------------------------------------------------
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic z,
    output logic co
);

    assign z  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one shared fa_cell processes a WIDTH-bit addition one
// bit per clock, LSB first. Operands are accepted on start while idle; busy
// is high while bits are shifted; done pulses for one cycle when sum/cout
// hold the final result. sum/cout keep their value until the next accepted
// start.
//
// Optional build macro: SERIAL_ADD_SUB_EN
//   When defined, adds input 'sub' (subtract a - b, sampled with start) and
//   output 'ovf' (signed overflow of the last operation).
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, honoured only in IDLE
//   a, b   : WIDTH-bit operands, sampled on accepted start
//   cin    : carry in, sampled on accepted start
//   sub    : (SERIAL_ADD_SUB_EN) subtract select
//   ovf    : (SERIAL_ADD_SUB_EN) carry-into-MSB xor carry-out-of-MSB
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result valid
//   sum    : result register (intermediate bits visible while busy)
//   cout   : final carry out
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_co;

    // Values loaded into the B shift register and carry flop on start.
    // Subtraction is a + ~b + 1, so the carry flop takes the "+1".
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    fa_cell u_fa_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .z  (cell_s),
        .co (cell_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    // New sum bit enters at the MSB so that after WIDTH
                    // shifts bit 0 of the result lands in sum[0].
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    carry <= cell_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        cout  <= cell_co;
`ifdef SERIAL_ADD_SUB_EN
                        // carry still holds the carry into the MSB here.
                        ovf   <= carry ^ cell_co;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_add_ctrl
